// File: rtl/clk_byte_word_packer_if.sv
// clk_byte_word_packer_if: byte-stream, flush and packed-word handshake bundle.
interface clk_byte_word_packer_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int CNT_W  = 16
);
   logic                    in_valid;
   logic [DATA_W-1:0]       in_data;
   logic                    in_ready;
   logic                    flush;
   logic                    flush_taken;
   logic                    out_valid;
   logic [DATA_W*LANES-1:0] out_data;
   logic [LANES-1:0]        out_keep;
   logic                    out_ready;
   logic [CNT_W-1:0]        word_cnt;
   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, flush_taken, out_valid, out_data, out_keep, word_cnt
   );
   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, flush_taken, out_valid, out_data, out_keep, word_cnt
   );
endinterface

// File: rtl/clk_byte_word_packer.sv
// clk_byte_word_packer: packs LANES bytes little-endian into words behind a 2-entry output FIFO,
// with flush of partial words carrying a byte-keep mask.
module clk_byte_word_packer #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int CNT_W  = 16
) (
   input logic                 clk,
   input logic                 rst,
   clk_byte_word_packer_if.slave bus
);
   localparam int IW = $clog2(LANES);
   localparam int WW = DATA_W * LANES;
   logic [WW-1:0]    acc_q, acc_d, acc_nx, head_q, head_d, tail_q, tail_d;
   logic [LANES-1:0] keep_q, keep_d, keep_nx, hkeep_q, hkeep_d, tkeep_q, tkeep_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [1:0]       cnt_q, cnt_d, occ;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             ft_q;
   logic             rdy, accept, take, pop, complete, push, clear;
   always_comb begin
      rdy      = !rst && (cnt_q != 2'd2);
      accept   = bus.in_valid && rdy;
      take     = !rst && bus.flush && (cnt_q != 2'd2);
      pop      = !rst && (cnt_q != 2'd0) && bus.out_ready;
      acc_nx   = acc_q;
      keep_nx  = keep_q;
      if (accept) begin
         acc_nx[idx_q*DATA_W +: DATA_W] = bus.in_data;
         keep_nx[idx_q]                 = 1'b1;
      end
      complete = accept && (idx_q == IW'(LANES - 1));
      // an empty flush is still consumed, it just pushes nothing
      push     = complete || (take && (keep_nx != '0));
      occ      = cnt_q - {1'b0, pop};
      head_d   = pop ? tail_q : head_q;
      hkeep_d  = pop ? tkeep_q : hkeep_q;
      tail_d   = tail_q;
      tkeep_d  = tkeep_q;
      if (push && (occ == 2'd0)) begin
         head_d  = acc_nx;
         hkeep_d = keep_nx;
      end
      if (push && (occ == 2'd1)) begin
         tail_d  = acc_nx;
         tkeep_d = keep_nx;
      end
      cnt_d    = occ + {1'b0, push};
      clear    = push || take;
      acc_d    = clear ? '0 : acc_nx;
      keep_d   = clear ? '0 : keep_nx;
      idx_d    = clear ? '0 : idx_q + IW'(accept);
      wcnt_d   = wcnt_q + CNT_W'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         keep_q  <= '0;
         idx_q   <= '0;
         head_q  <= '0;
         hkeep_q <= '0;
         tail_q  <= '0;
         tkeep_q <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         ft_q    <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         keep_q  <= keep_d;
         idx_q   <= idx_d;
         head_q  <= head_d;
         hkeep_q <= hkeep_d;
         tail_q  <= tail_d;
         tkeep_q <= tkeep_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         ft_q    <= take;
      end
   end
   assign bus.in_ready    = rdy;
   assign bus.out_valid   = !rst && (cnt_q != 2'd0);
   assign bus.out_data    = rst ? '0 : head_q;
   assign bus.out_keep    = rst ? '0 : hkeep_q;
   assign bus.flush_taken = !rst && ft_q;
   assign bus.word_cnt    = wcnt_q;
endmodule

// File: tb/tb_clk_byte_word_packer.sv
// tb_clk_byte_word_packer: directed plus random stimulus against a queue-based packing model.
module tb_clk_byte_word_packer;
   localparam int DW = 8;
   localparam int LN = 4;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   ft_cnt = 0;
   logic [7:0]  part[$];
   logic [35:0] exp_q[$];
   logic [31:0] seen_d[$];
   logic [3:0]  seen_k[$];
   int   m_wcnt = 0;
   bit   m_ft = 0;
   bit   m_acc = 0;
   bit   m_taken = 0;
   clk_byte_word_packer_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) bus ();
   clk_byte_word_packer #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      bit e_rdy, e_val, have_w;
      logic [35:0] w;
      #1;
      e_rdy = exp_q.size() < 2;
      e_val = exp_q.size() != 0;
      if (rst) begin
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data", bus.out_data, 0);
         chk("rst_out_keep", bus.out_keep, 0);
         chk("rst_flush_taken", bus.flush_taken, 0);
      end else begin
         chk("in_ready", bus.in_ready, e_rdy);
         chk("out_valid", bus.out_valid, e_val);
         if (e_val) begin
            chk("out_data", bus.out_data, exp_q[0][31:0]);
            chk("out_keep", bus.out_keep, exp_q[0][35:32]);
         end
         chk("flush_taken", bus.flush_taken, m_ft);
         chk("word_cnt", bus.word_cnt, m_wcnt);
      end
      if (!rst && bus.out_valid && bus.out_ready) begin
         seen_d.push_back(bus.out_data);
         seen_k.push_back(bus.out_keep);
      end
      if (!rst && bus.flush_taken) ft_cnt++;
      m_acc = 0;
      m_taken = 0;
      if (rst) begin
         part.delete();
         exp_q.delete();
         m_wcnt = 0;
         m_ft = 0;
      end else begin
         m_acc = bus.in_valid && e_rdy;
         m_taken = bus.flush && e_rdy;
         if (m_acc) part.push_back(bus.in_data);
         have_w = 0;
         w = '0;
         if (part.size() == LN || (m_taken && part.size() > 0)) begin
            foreach (part[i]) w[8*i +: 8] = part[i];
            w[35:32] = 4'((1 << part.size()) - 1);
            have_w = 1;
            part.delete();
         end
         if (e_val && bus.out_ready) begin
            void'(exp_q.pop_front());
            m_wcnt = (m_wcnt + 1) % (1 << CW);
         end
         if (have_w) exp_q.push_back(w);
         m_ft = m_taken;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic put_byte(logic [7:0] b);
      bit done = 0;
      bus.in_valid = 1'b1;
      bus.in_data = b;
      for (int n = 0; n < 50 && !done; n++) begin
         tick();
         done = m_acc;
      end
      if (!done) chk("put_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask
   task automatic drain();
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
      chk("drain_empty", exp_q.size(), 0);
      tick();
   endtask
   initial begin
      int n0, f0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset_word_cnt", bus.word_cnt, 0);
      // basic word
      put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
      drain();
      chk("w1_data", seen_d[$], 32'h44332211);
      chk("w1_keep", seen_k[$], 4'hF);
      chk("w1_cnt", bus.word_cnt, 1);
      // backpressure fills the FIFO
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) put_byte(8'(i));
      chk("full_in_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      for (int i = 9; i <= 12; i++) put_byte(8'(i));
      drain();
      chk("bp_w0", seen_d[seen_d.size()-3], 32'h04030201);
      chk("bp_w1", seen_d[seen_d.size()-2], 32'h08070605);
      chk("bp_w2", seen_d[seen_d.size()-1], 32'h0C0B0A09);
      chk("bp_cnt", bus.word_cnt, 4);
      // partial flush
      f0 = ft_cnt;
      put_byte(8'hAA); put_byte(8'hBB);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      drain();
      chk("fl_data", seen_d[$], 32'h0000BBAA);
      chk("fl_keep", seen_k[$], 4'h3);
      chk("fl_pulses", ft_cnt - f0, 1);
      put_byte(8'hCC); put_byte(8'hDD); put_byte(8'hEE); put_byte(8'hFF);
      drain();
      chk("fl_next", seen_d[$], 32'hFFEEDDCC);
      // flush blocked by a full FIFO
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) put_byte(8'(8'h20 + i));
      f0 = ft_cnt;
      bus.flush = 1'b1;
      tick(); tick(); tick();
      chk("ff_no_early", ft_cnt - f0, 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tick();
      chk("ff_taken", m_taken, 1);
      bus.flush = 1'b0;
      tick();
      chk("ff_pulse", ft_cnt - f0, 1);
      bus.out_ready = 1'b1;
      drain();
      // reset mid-word
      put_byte(8'h01); put_byte(8'h02); put_byte(8'h03);
      n0 = seen_d.size();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      put_byte(8'h55); put_byte(8'h66); put_byte(8'h77); put_byte(8'h88);
      drain();
      chk("rs_count", seen_d.size() - n0, 1);
      chk("rs_data", seen_d[$], 32'h88776655);
      chk("rs_keep", seen_k[$], 4'hF);
      chk("rs_cnt", bus.word_cnt, 1);
      // counter wrap
      for (int w = 0; w < 15; w++) begin
         for (int b = 0; b < 4; b++) put_byte(8'($urandom));
         drain();
      end
      chk("wrap_16", bus.word_cnt, 0);
      for (int b = 0; b < 4; b++) put_byte(8'($urandom));
      drain();
      chk("wrap_17", bus.word_cnt, 1);
      // random traffic
      for (int c = 0; c < 600; c++) begin
         bus.in_valid = 1'($urandom_range(0, 3) != 0);
         bus.in_data = 8'($urandom);
         bus.out_ready = 1'($urandom_range(0, 2) != 0);
         if (bus.flush && m_taken) bus.flush = 1'b0;
         else if (!bus.flush && $urandom_range(0, 7) == 0) bus.flush = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
